i2c_slave_addr_detect: RTL and testbench
========================================

Name: i2c_slave_addr_detect

Overview:
- Front-end stage of the I2C slave. It sits directly upstream of the data-in stage.
- Synchronises raw SCL/SDA into FPGA_clk and supplies the current/previous sampled line values, plus START/STOP events.
- Receives and ACKs the 7-bit address + R/W byte, then hands the bus to the data-in stage via enable until that stage reports done or a STOP/repeated START occurs.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave answers to.
- SYNC_STAGES, 2, synchroniser flops per line (minimum 2).

Ports:
- FPGA_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SCL_in  input  1  raw I2C clock from pad.
- SDA_in  input  1  raw I2C data from pad.
- data_done  input  1  done from data-in stage; ends the data phase.
- SCL  output  1  synchronised SCL.
- SCL_prev  output  1  SCL delayed one FPGA_clk.
- SDA  output  1  synchronised SDA.
- SDA_prev  output  1  SDA delayed one FPGA_clk.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- enable  output  1  data-in stage enable; high throughout the data phase.
- SDA_down  output  1  request to pull SDA low (address ACK).
- addr_match  output  1  high from the ACK phase until STOP/START; address matched with R/W=0.
- busy  output  1  high between START and STOP (bus owned by some master).

Behaviour:
- Reset values:
  - Synchroniser flops, SCL, SCL_prev, SDA, SDA_prev = 1 (idle bus).
  - All other outputs = 0.
  - State = IDLE; shift register = 0; bit counter = 0.
- Latency: SCL/SDA lag the pads by SYNC_STAGES cycles; *_prev lags by one more.
- Edge and event definitions:
  - SCL rise = !SCL_prev && SCL; SCL fall = SCL_prev && !SCL.
  - START = SCL && SCL_prev && SDA_prev && !SDA.
  - STOP = SCL && SCL_prev && !SDA_prev && SDA.
  - start_det/stop_det are registered, so each pulses the cycle after its condition is seen.
- busy: set on START; cleared on STOP.
- States: IDLE, ADDR, ACK_WAIT, ACK, DATA, IGNORE.
  - IDLE: START -> ADDR; bit counter cleared.
  - ADDR:
    - Each SCL rise shifts SDA into shift[0] (MSB first) and increments the counter.
    - On the 8th SCL rise, evaluate shift[7:1]==SLAVE_ADDR && shift[0]==0.
    - Match -> ACK_WAIT. Otherwise -> IGNORE; no ACK (R/W=1 is not supported).
  - ACK_WAIT: next SCL fall -> ACK. SDA_down and addr_match are asserted that same cycle.
  - ACK: SDA_down is held through the 9th SCL high. On the next SCL fall, SDA_down deasserts, enable asserts, and state -> DATA.
  - DATA:
    - enable stays high.
    - data_done=1 -> IGNORE with enable cleared the following cycle.
    - Data-phase SDA transitions are owned by the data-in stage; this block only watches for START/STOP.
  - IGNORE: wait for START or STOP.
- Global rules, which take priority over all per-state transitions:
  - STOP in any state -> IDLE. Clears enable, SDA_down, addr_match and the bit counter in the same update.
  - START in any state (repeated START) -> ADDR. Same clears; counter = 0.
  - START and STOP cannot both be true in one cycle.
- SDA_down must never be asserted while SCL is high except during the ACK bit. It is released only on an SCL fall or by STOP/START/rst.
- Asynchronous rst mid-transfer: immediate return to reset values; no ACK is driven afterwards.
- Counter is 4 bits wide; it never exceeds 8 in ADDR and does not wrap.

Decomposition:
- Package i2c_pkg:
  - typedef enum for the state type (IDLE, ADDR, ACK_WAIT, ACK, DATA, IGNORE).
  - I2C_ADDR_WIDTH = 7.
  - I2C_BYTE_BITS = 8.
  - The data-in stage reuses the constants.
- Sub-module i2c_sync_edge:
  - Parameterised SYNC_STAGES synchroniser plus one prev register, reset to 1.
  - Instantiated twice (SCL, SDA).
- FSM and shift register live in the top.

Test Plan:
- Reset then idle bus: SCL/SDA held 1 -> all outputs at reset values, SCL=SDA=1, no start_det.
- START, address 0x42, W (byte 0x84):
  - start_det one pulse; SDA_down rises on the 8th SCL fall and falls on the 9th SCL fall.
  - enable=1 and addr_match=1 afterwards.
- START, address 0x43, W -> SDA_down never asserts, enable=0, state IGNORE until STOP; stop_det pulse, busy=0.
- START, address 0x42, R (byte 0x85) -> no ACK, enable stays 0.
- Matched write, data_done pulsed after 2 bytes -> enable falls the following cycle; later STOP -> IDLE.
- Repeated START mid-DATA, then address 0x42 W -> enable drops within 1 cycle of the START condition; re-ACK occurs.
- Assert rst during the ACK bit -> SDA_down=0 immediately (asynchronously); outputs return to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state type and byte/address geometry.
// Also used by the downstream data-in stage.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_WIDTH = 7;
    localparam int unsigned I2C_BYTE_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ACK_WAIT = 3'd2,
        ACK      = 3'd3,
        DATA     = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_e;

endpackage

// File: rtl/i2c_slave_addr_detect_if.sv
// Bus-side signal bundle of the I2C address detector.
// slave: the detector itself; master: whatever drives the pads / consumes the outputs.
interface i2c_slave_addr_detect_if;

    logic SCL_in;
    logic SDA_in;
    logic data_done;
    logic SCL;
    logic SCL_prev;
    logic SDA;
    logic SDA_prev;
    logic start_det;
    logic stop_det;
    logic enable;
    logic SDA_down;
    logic addr_match;
    logic busy;

    modport slave (
        input  SCL_in, SDA_in, data_done,
        output SCL, SCL_prev, SDA, SDA_prev, start_det, stop_det,
               enable, SDA_down, addr_match, busy
    );

    modport master (
        output SCL_in, SDA_in, data_done,
        input  SCL, SCL_prev, SDA, SDA_prev, start_det, stop_det,
               enable, SDA_down, addr_match, busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one raw I2C line, plus a one-cycle-delayed copy.
// Resets to 1 so an idle bus is seen coming out of reset.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic prev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign prev_o = prev_q;

endmodule

// File: rtl/i2c_slave_addr_detect.sv
// I2C slave front end: line synchronisation, START/STOP detection, address
// reception and ACK, then hands the bus to the data-in stage via enable.
module i2c_slave_addr_detect
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h42,
    parameter int unsigned               SYNC_STAGES = 2
) (
    input  logic                   FPGA_clk,
    input  logic                   rst,
    i2c_slave_addr_detect_if.slave bus
);

    logic scl, scl_prev, sda, sda_prev;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk_i  (FPGA_clk),
        .rst_i  (rst),
        .d_i    (bus.SCL_in),
        .q_o    (scl),
        .prev_o (scl_prev)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk_i  (FPGA_clk),
        .rst_i  (rst),
        .d_i    (bus.SDA_in),
        .q_o    (sda),
        .prev_o (sda_prev)
    );

    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = !scl_prev && scl;
    assign scl_fall = scl_prev && !scl;
    assign start_c  = scl && scl_prev && sda_prev && !sda;
    assign stop_c   = scl && scl_prev && !sda_prev && sda;

    i2c_state_e                 state_q, state_d;
    logic [I2C_BYTE_BITS-1:0]   shift_q, shift_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       start_det_q, start_det_d;
    logic                       stop_det_q, stop_det_d;
    logic                       enable_q, enable_d;
    logic                       sda_down_q, sda_down_d;
    logic                       addr_match_q, addr_match_d;
    logic                       busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        enable_d     = enable_q;
        sda_down_d   = sda_down_q;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        start_det_d  = start_c;
        stop_det_d   = stop_c;

        if (start_c) begin
            busy_d = 1'b1;
        end else if (stop_c) begin
            busy_d = 1'b0;
        end

        // STOP / repeated START override whatever the current state is doing
        if (stop_c || start_c) begin
            state_d      = stop_c ? IDLE : ADDR;
            enable_d     = 1'b0;
            sda_down_d   = 1'b0;
            addr_match_d = 1'b0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[I2C_BYTE_BITS-2:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
                            // Only writes are acknowledged; reads fall through to IGNORE
                            if (shift_d[I2C_BYTE_BITS-1:1] == SLAVE_ADDR && !shift_d[0]) begin
                                state_d = ACK_WAIT;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ACK_WAIT: begin
                    if (scl_fall) begin
                        state_d      = ACK;
                        sda_down_d   = 1'b1;
                        addr_match_d = 1'b1;
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        state_d    = DATA;
                        sda_down_d = 1'b0;
                        enable_d   = 1'b1;
                    end
                end
                DATA: begin
                    if (bus.data_done) begin
                        state_d  = IGNORE;
                        enable_d = 1'b0;
                    end
                end
                IGNORE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            enable_q     <= 1'b0;
            sda_down_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            enable_q     <= enable_d;
            sda_down_q   <= sda_down_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.SCL        = scl;
    assign bus.SCL_prev   = scl_prev;
    assign bus.SDA        = sda;
    assign bus.SDA_prev   = sda_prev;
    assign bus.start_det  = start_det_q;
    assign bus.stop_det   = stop_det_q;
    assign bus.enable     = enable_q;
    assign bus.SDA_down   = sda_down_q;
    assign bus.addr_match = addr_match_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_addr_detect.sv
// Self-checking bench for i2c_slave_addr_detect: bit-level I2C master with
// open-drain SDA, table-driven address vectors and randomized transactions.
module tb_i2c_slave_addr_detect;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int Q = 6;  // FPGA_clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m, done_m;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0, stop_cnt = 0, ack_cnt = 0;
    logic dn_prev = 1'b0;

    always #5 clk = ~clk;

    i2c_slave_addr_detect_if bus ();

    assign bus.SCL_in    = scl_m;
    assign bus.SDA_in    = sda_m & ~bus.SDA_down;  // open-drain wired-AND
    assign bus.data_done = done_m;

    i2c_slave_addr_detect #(
        .SLAVE_ADDR  (ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .FPGA_clk (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.start_det) start_cnt <= start_cnt + 1;
        if (bus.stop_det)  stop_cnt  <= stop_cnt + 1;
        dn_prev <= bus.SDA_down;
        if (bus.SDA_down && !dn_prev) ack_cnt <= ack_cnt + 1;
    end

    // Transaction-level reference: a write to our address is the only thing acknowledged
    function automatic logic model_ack(input logic [7:0] b);
        return (b[7:1] == ADDR) && (b[0] == 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b, output logic dn_mid);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        dn_mid = bus.SDA_down;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // Address byte plus the 9th (ACK) clock with the master releasing SDA
    task automatic send_addr(input logic [7:0] b, output logic any_dn,
                             output logic dn_after8, output logic ack_dn);
        logic dn;
        any_dn = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], dn);
            any_dn |= dn;
        end
        dn_after8 = bus.SDA_down;
        send_bit(1'b1, ack_dn);
    endtask

    task automatic send_data(input logic [7:0] b);
        logic dn;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dn);
        send_bit(1'b1, dn);
    endtask

    task automatic addr_phase(input string tag, input logic [7:0] b, input logic exp);
        logic any_dn, dn8, ack_dn;
        int   s0;
        s0 = start_cnt;
        i2c_start();
        check({tag, " start_det pulses"}, start_cnt - s0, 1);
        check({tag, " busy after start"}, bus.busy, 1'b1);
        send_addr(b, any_dn, dn8, ack_dn);
        check({tag, " SDA_down in addr bits"}, any_dn, 1'b0);
        check({tag, " SDA_down after 8th fall"}, dn8, exp);
        check({tag, " SDA_down 9th high"}, ack_dn, exp);
        check({tag, " SDA_down after 9th fall"}, bus.SDA_down, 1'b0);
        check({tag, " enable"}, bus.enable, exp);
        check({tag, " addr_match"}, bus.addr_match, exp);
    endtask

    task automatic stop_phase(input string tag);
        int p0;
        p0 = stop_cnt;
        i2c_stop();
        check({tag, " stop_det pulses"}, stop_cnt - p0, 1);
        check({tag, " busy after stop"}, bus.busy, 1'b0);
        check({tag, " enable after stop"}, bus.enable, 1'b0);
        check({tag, " addr_match after stop"}, bus.addr_match, 1'b0);
    endtask

    task automatic pulse_done(input string tag);
        check({tag, " enable before done"}, bus.enable, 1'b1);
        done_m = 1'b1; tick(1);
        done_m = 1'b0;
        check({tag, " enable after done"}, bus.enable, 1'b0);
        check({tag, " addr_match after done"}, bus.addr_match, 1'b1);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       ack;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   a0, s0;
        logic dn;
        logic [7:0] b;
        logic exp, open;

        vecs[0] = '{8'h84, 1'b1};  // 0x42 write
        vecs[1] = '{8'h86, 1'b0};  // 0x43 write
        vecs[2] = '{8'h85, 1'b0};  // 0x42 read
        vecs[3] = '{8'h04, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'hC4, 1'b0};  // 0x62 write

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; done_m = 1'b0;
        tick(3);
        check("reset SCL", bus.SCL, 1'b1);
        check("reset SDA", bus.SDA, 1'b1);
        check("reset SCL_prev", bus.SCL_prev, 1'b1);
        check("reset SDA_prev", bus.SDA_prev, 1'b1);
        check("reset enable", bus.enable, 1'b0);
        check("reset SDA_down", bus.SDA_down, 1'b0);
        check("reset addr_match", bus.addr_match, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick(10);
        check("idle start_det count", start_cnt, 0);
        check("idle stop_det count", stop_cnt, 0);
        check("idle busy", bus.busy, 1'b0);
        check("idle SCL/SDA", {bus.SCL, bus.SDA}, 2'b11);

        foreach (vecs[i]) begin
            a0 = ack_cnt;
            addr_phase($sformatf("vec%0d", i), vecs[i].byte_v, vecs[i].ack);
            check($sformatf("vec%0d ack count", i), ack_cnt - a0, vecs[i].ack);
            stop_phase($sformatf("vec%0d", i));
        end

        // Matched write, two data bytes, data_done, then STOP
        addr_phase("done", 8'h84, 1'b1);
        send_data(8'hA5);
        send_data(8'h3C);
        check("done enable after bytes", bus.enable, 1'b1);
        pulse_done("done");
        tick(Q);
        stop_phase("done");

        // Repeated START mid-DATA, then re-addressed
        addr_phase("rs1", 8'h84, 1'b1);
        send_data(8'h5A);
        a0 = ack_cnt;
        addr_phase("rs2", 8'h84, 1'b1);
        check("rs re-ack count", ack_cnt - a0, 1);
        stop_phase("rs");

        // Randomized transactions against the transaction-level model
        open = 1'b0;
        for (int t = 0; t < 20; t++) begin
            b = ($urandom_range(0, 1) == 0) ? 8'h84 : 8'($urandom);
            exp = model_ack(b);
            a0 = ack_cnt;
            addr_phase($sformatf("rnd%0d", t), b, exp);
            if (open) check($sformatf("rnd%0d rs cleared state", t), bus.enable, exp);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_data(8'($urandom));
            check($sformatf("rnd%0d enable in data", t), bus.enable, exp);
            check($sformatf("rnd%0d ack count", t), ack_cnt - a0, exp);
            if (exp && $urandom_range(0, 1) == 1) pulse_done($sformatf("rnd%0d", t));
            if ($urandom_range(0, 1) == 1) begin
                stop_phase($sformatf("rnd%0d", t));
                open = 1'b0;
            end else begin
                open = 1'b1;
            end
        end
        if (open) stop_phase("rnd end");

        // Asynchronous reset during the ACK bit
        s0 = start_cnt;
        i2c_start();
        check("rst start_det", start_cnt - s0, 1);
        for (int i = 7; i >= 0; i--) begin
            b = 8'h84;
            send_bit(b[i], dn);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check("rst SDA_down before rst", bus.SDA_down, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("rst SDA_down async", bus.SDA_down, 1'b0);
        check("rst addr_match async", bus.addr_match, 1'b0);
        check("rst busy async", bus.busy, 1'b0);
        check("rst SDA async", bus.SDA, 1'b1);
        tick(Q);
        scl_m = 1'b0; tick(Q);
        rst = 1'b0;
        a0 = ack_cnt;
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), dn);
        check("rst no ack afterwards", ack_cnt - a0, 0);
        check("rst enable afterwards", bus.enable, 1'b0);
        i2c_stop();
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
